// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC scan/average datapath.
package adc_pkg;

   localparam int ADC_WIDTH = 12;
   localparam int NUM_CHAN  = 8;

   typedef logic [2:0]           chan_t;
   typedef logic [ADC_WIDTH-1:0] sample_t;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      ACCUM,
      EMIT
   } scan_state_t;

endpackage

// File: rtl/chan_rr_select.sv
// Round-robin search for the next enabled channel strictly above cur, wrapping 7->0.
// If cur is the only enabled channel, the search comes back to cur itself.
module chan_rr_select
   import adc_pkg::*;
(
   input  logic [NUM_CHAN-1:0] mask,
   input  chan_t               cur,
   output chan_t               nxt,
   output logic                any_set
);

   chan_t idx;
   logic  found;

   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
      nxt   = cur;
      idx   = cur;
      found = 1'b0;
      // i == NUM_CHAN wraps idx back to cur, which covers the single-channel mask
      for (int i = 1; i <= NUM_CHAN; i++) begin
         idx = cur + chan_t'(i);
         if (!found && mask[idx]) begin
            nxt   = idx;
            found = 1'b1;
         end
      end
   end

   assign any_set = |mask;

endmodule

// File: rtl/adc_scan_averager.sv
// Round-robin ADC channel scanner: discards the stale frame after each switch, averages 2^AVG_LOG2 samples.
// Optional peak tracking is enabled with `define ADC_SCAN_PEAK_EN (adds output avg_peak).
module adc_scan_averager
   import adc_pkg::*;
#(
   parameter int FRAME_CYCLES = 19,
   parameter int AVG_LOG2     = 3
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_CHAN-1:0] chan_mask,
   input  sample_t             result,
   output chan_t               chan,
   output sample_t             avg,
   output chan_t               avg_chan,
   output logic                avg_valid,
   output logic                busy
`ifdef ADC_SCAN_PEAK_EN
   ,
   output sample_t             avg_peak
`endif
);

   localparam int FC_W  = ($clog2(FRAME_CYCLES) > 0) ? $clog2(FRAME_CYCLES) : 1;
   localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
   localparam int SC_W  = AVG_LOG2 + 1;

   localparam logic [FC_W-1:0] FRAME_LAST = FC_W'(FRAME_CYCLES - 1);
   localparam logic [SC_W-1:0] SAMP_LAST  = SC_W'((1 << AVG_LOG2) - 1);

   scan_state_t      state;
   logic [FC_W-1:0]  frame_cnt;
   logic             frame_end;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [SC_W-1:0]  samp_cnt;
   chan_t            rr_cur;
   chan_t            rr_nxt;
   logic             rr_any;

   // Must stay in lockstep with the ADC interface frame; both leave reset together.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         frame_cnt <= FRAME_LAST;
      end else if (frame_cnt == '0) begin
         frame_cnt <= FRAME_LAST;
      end else begin
         frame_cnt <= frame_cnt - 1'b1;
      end
   end

   assign frame_end = (frame_cnt == '0);

   // From IDLE, searching above channel 7 yields the lowest enabled channel.
   assign rr_cur  = (state == IDLE) ? chan_t'(NUM_CHAN - 1) : chan;
   assign acc_sum = acc + ACC_W'(result);

   chan_rr_select u_rr (
      .mask    (chan_mask),
      .cur     (rr_cur),
      .nxt     (rr_nxt),
      .any_set (rr_any)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         chan      <= '0;
         avg       <= '0;
         avg_chan  <= '0;
         avg_valid <= 1'b0;
         acc       <= '0;
         samp_cnt  <= '0;
      end else begin
         avg_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (frame_end && rr_any) begin
                  chan  <= rr_nxt;
                  state <= SETTLE;
               end
            end
            SETTLE: begin
               // The result captured here belongs to the previous channel and is dropped.
               if (frame_end) begin
                  acc      <= '0;
                  samp_cnt <= '0;
                  state    <= ACCUM;
               end
            end
            ACCUM: begin
               if (frame_end) begin
                  acc      <= acc_sum;
                  samp_cnt <= samp_cnt + SC_W'(1);
                  if (samp_cnt == SAMP_LAST) begin
                     state <= EMIT;
                  end
               end
            end
            EMIT: begin
               avg       <= sample_t'(acc >> AVG_LOG2);
               avg_chan  <= chan;
               avg_valid <= 1'b1;
               if (rr_any) begin
                  chan  <= rr_nxt;
                  state <= SETTLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

`ifdef ADC_SCAN_PEAK_EN
   sample_t peak_run;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         peak_run <= '0;
         avg_peak <= '0;
      end else begin
         if (state == SETTLE && frame_end) begin
            peak_run <= '0;
         end else if (state == ACCUM && frame_end && result > peak_run) begin
            peak_run <= result;
         end
         if (state == EMIT) begin
            avg_peak <= peak_run;
         end
      end
   end
`endif

endmodule

// File: tb/tb_adc_scan_averager.sv
// Directed self-checking bench for adc_scan_averager (FRAME_CYCLES=19, AVG_LOG2=3).
// With FRAME_CYCLES=19 the first avg_valid lands 191 clocks after reset release, then every 171 clocks.
module tb_adc_scan_averager;
   import adc_pkg::*;

   logic          clk;
   logic          reset_n;
   logic [7:0]    chan_mask;
   sample_t       result;
   chan_t         chan;
   sample_t       avg;
   chan_t         avg_chan;
   logic          avg_valid;
   logic          busy;
`ifdef ADC_SCAN_PEAK_EN
   sample_t       avg_peak;
`endif

   int n_cmp;
   int n_err;
   int cyc;
   int n_valid;

   adc_scan_averager #(.FRAME_CYCLES(19), .AVG_LOG2(3)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .chan_mask (chan_mask),
      .result    (result),
      .chan      (chan),
      .avg       (avg),
      .avg_chan  (avg_chan),
      .avg_valid (avg_valid),
      .busy      (busy)
`ifdef ADC_SCAN_PEAK_EN
      ,
      .avg_peak  (avg_peak)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Posedges since reset release; at the negedge after edge n, cyc == n.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (avg_valid === 1'b1) n_valid++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic do_reset(input logic [7:0] mask, input sample_t res);
      reset_n   = 1'b0;
      chan_mask = mask;
      result    = res;
      repeat (3) @(negedge clk);
      check("rst chan", chan, 0);
      check("rst avg", avg, 0);
      check("rst avg_chan", avg_chan, 0);
      check("rst avg_valid", avg_valid, 0);
      check("rst busy", busy, 0);
`ifdef ADC_SCAN_PEAK_EN
      check("rst avg_peak", avg_peak, 0);
`endif
      reset_n = 1'b1;
   endtask

   task automatic wait_valid(input string tag, input int exp_cyc, input int exp_avg, input int exp_ch);
      int n;
      n = 0;
      while (avg_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, " valid_seen"}, avg_valid, 1);
      check({tag, " cycle"}, cyc, exp_cyc);
      check({tag, " avg"}, avg, exp_avg);
      check({tag, " avg_chan"}, avg_chan, exp_ch);
      @(negedge clk);
      check({tag, " pulse_one_cycle"}, avg_valid, 0);
   endtask

   initial begin
      int v0;
`ifdef ADC_SCAN_PEAK_EN
      int w1[8];
`endif
      n_cmp     = 0;
      n_err     = 0;
      n_valid   = 0;
      reset_n   = 1'b1;
      chan_mask = '0;
      result    = '0;

      // 1: single channel, constant input, latency 19 + 19 + 8*19 + 1
      do_reset(8'h01, 12'd1000);
      wait_cyc(18);
      check("t1 busy_before_frame_end", busy, 0);
      wait_cyc(19);
      check("t1 busy_after_idle_exit", busy, 1);
      check("t1 chan_after_idle_exit", chan, 0);
      wait_valid("t1", 191, 1000, 0);

      // 2: two channels, result switches one frame after each chan change
      do_reset(8'h05, 12'd100);
      wait_valid("t2 w0", 191, 100, 0);
      check("t2 chan_to_2", chan, 2);
      wait_cyc(209);
      result = 12'd300;
      wait_valid("t2 w1", 362, 300, 2);
      check("t2 chan_to_0", chan, 0);
      wait_cyc(380);
      result = 12'd100;
      wait_valid("t2 w2", 533, 100, 0);
      wait_cyc(551);
      result = 12'd300;
      wait_valid("t2 w3", 704, 300, 2);

      // 3: ramp 0..7 truncates to 3; all-ones stays 0xFFF
      do_reset(8'h01, 12'd0);
      for (int k = 0; k < 8; k++) begin
         wait_cyc(38 + 19 * k);
         result = sample_t'(k);
      end
      wait_valid("t3 ramp", 191, 3, 0);
      result = 12'hFFF;
      wait_valid("t3 full_scale", 362, 12'hFFF, 0);

      // 4: wrap 0 -> 7 -> 0, then mask cleared mid-window
      do_reset(8'h81, 12'd500);
      wait_valid("t4 w0", 191, 500, 0);
      check("t4 chan_to_7", chan, 7);
      wait_valid("t4 w1", 362, 500, 7);
      check("t4 chan_wrap_0", chan, 0);
      wait_valid("t4 w2", 533, 500, 0);
      check("t4 chan_to_7_again", chan, 7);
      wait_cyc(600);
      chan_mask = 8'h00;
      wait_valid("t4 w3_after_clear", 704, 500, 7);
      check("t4 busy_idle", busy, 0);
      check("t4 chan_held", chan, 7);
      v0 = n_valid;
      wait_cyc(800);
      check("t4 no_more_valid", n_valid, v0);
      check("t4 still_idle", busy, 0);
      check("t4 chan_still_held", chan, 7);
      check("t4 avg_held", avg, 500);
      check("t4 avg_chan_held", avg_chan, 7);

      // 5: reset after 4 samples of the second window
      do_reset(8'h08, 12'd1000);
      wait_valid("t5 pre", 191, 1000, 3);
      wait_cyc(290);
      check("t5 busy_before_reset", busy, 1);
      reset_n = 1'b0;
      #1;
      check("t5 mid_rst chan", chan, 0);
      check("t5 mid_rst avg", avg, 0);
      check("t5 mid_rst avg_chan", avg_chan, 0);
      check("t5 mid_rst avg_valid", avg_valid, 0);
      check("t5 mid_rst busy", busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      v0 = n_valid;
      wait_cyc(190);
      check("t5 no_partial_valid", n_valid, v0);
      wait_valid("t5 post", 191, 1000, 3);

`ifdef ADC_SCAN_PEAK_EN
      // 6: peak of each window, independent across windows
      w1 = '{5, 900, 12, 7, 3, 0, 1, 2};
      do_reset(8'h01, 12'd5);
      for (int k = 0; k < 8; k++) begin
         wait_cyc(38 + 19 * k);
         result = sample_t'(w1[k]);
      end
      wait_valid("t6 w0", 191, 116, 0);
      check("t6 w0 avg_peak", avg_peak, 900);
      result = 12'd4000;
      wait_cyc(209);
      result = 12'd40;
      wait_cyc(342);
      result = 12'd60;
      wait_valid("t6 w1", 362, 42, 0);
      check("t6 w1 avg_peak", avg_peak, 60);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
